// File: rtl/eth_frame_builder.sv
// Builds one Ethernet frame per start request from a byte-wide template RAM and
// streams it on an 8-bit AXI-Stream master, with LFSR / sequence-number byte substitution.
module eth_frame_builder #(
  parameter int unsigned MIN_SIZE = 60,
  parameter int unsigned MAX_SIZE = 1514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] frame_size,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] seq_num,
  output logic [10:0] tmpl_addr,
  input  logic [7:0]  tmpl_data,
  input  logic [1:0]  tmpl_flags,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  localparam int unsigned AW = 11;
  localparam int unsigned EW = 10;
  localparam logic [7:0]  LFSR_SEED = 8'd11;

  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, DONE} state_t;

  state_t        state;
  logic [AW-1:0] len;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] out_idx;
  logic [31:0]   seq_snap;
  logic [7:0]    lfsr;
  logic [2:0]    seq_cnt;
  logic          rd_req;
  logic          ret_valid;
  logic [1:0]    cnt;
  logic [EW-1:0] buf0;
  logic [EW-1:0] buf1;

  logic          fire;
  logic          load;
  logic          bypass;
  logic          pop;
  logic          push;
  logic          issue;
  logic [2:0]    occ;
  logic [EW-1:0] ret_entry;
  logic [EW-1:0] src;
  logic [7:0]    sub_byte;
  logic [7:0]    lfsr_next;
  logic [AW-1:0] len_c;

  // Skid-buffer flow control: reads in flight plus buffered bytes never exceed two,
  // so a stalled output always has room for every byte already requested from RAM.
  always_comb begin
    fire      = m_axis_tvalid & m_axis_tready;
    ret_entry = {tmpl_flags, tmpl_data};
    load      = (state == STREAM) && (!m_axis_tvalid || m_axis_tready) &&
                ((cnt != 2'd0) || ret_valid) && (out_idx < len);
    bypass    = load && (cnt == 2'd0);
    pop       = load && !bypass;
    push      = ret_valid && !bypass;
    occ       = 3'(cnt) + 3'(rd_req) + 3'(ret_valid);
    issue     = ((state == PREFETCH) || (state == STREAM)) && (rd_idx < len) &&
                ((occ - 3'(load)) < 3'd2);
    src       = (cnt != 2'd0) ? buf0 : ret_entry;
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    if (frame_size < AW'(MIN_SIZE))      len_c = AW'(MIN_SIZE);
    else if (frame_size > AW'(MAX_SIZE)) len_c = AW'(MAX_SIZE);
    else                                 len_c = frame_size;
  end

  // Byte substitution: LFSR wins over sequence bytes; sequence bytes go out MSB first, four at most.
  always_comb begin
    sub_byte = src[7:0];
    if (src[8]) begin
      sub_byte = lfsr;
    end else if (src[9] && !seq_cnt[2]) begin
      case (seq_cnt[1:0])
        2'd0:    sub_byte = seq_snap[31:24];
        2'd1:    sub_byte = seq_snap[23:16];
        2'd2:    sub_byte = seq_snap[15:8];
        default: sub_byte = seq_snap[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      seq_num       <= 32'd0;
      tmpl_addr     <= '0;
      m_axis_tdata  <= 8'd0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      len           <= '0;
      rd_idx        <= '0;
      out_idx       <= '0;
      seq_snap      <= 32'd0;
      lfsr          <= LFSR_SEED;
      seq_cnt       <= 3'd0;
      rd_req        <= 1'b0;
      ret_valid     <= 1'b0;
      cnt           <= 2'd0;
      buf0          <= '0;
      buf1          <= '0;
    end else begin
      frame_done <= 1'b0;
      ret_valid  <= rd_req;
      rd_req     <= issue;
      if (issue) begin
        tmpl_addr <= rd_idx;
        rd_idx    <= rd_idx + AW'(1);
      end

      if (pop && push) begin
        if (cnt == 2'd2) begin
          buf0 <= buf1;
          buf1 <= ret_entry;
        end else begin
          buf0 <= ret_entry;
        end
      end else if (pop) begin
        buf0 <= buf1;
        cnt  <= cnt - 2'd1;
      end else if (push) begin
        if (cnt == 2'd0) buf0 <= ret_entry;
        else             buf1 <= ret_entry;
        cnt <= cnt + 2'd1;
      end

      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sub_byte;
        m_axis_tlast  <= (out_idx == len - AW'(1));
        out_idx       <= out_idx + AW'(1);
        lfsr          <= lfsr_next;
        if (src[9] && !src[8] && !seq_cnt[2]) seq_cnt <= seq_cnt + 3'd1;
      end else if (fire) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            len       <= len_c;
            seq_snap  <= seq_num;
            busy      <= 1'b1;
            tmpl_addr <= '0;
            rd_idx    <= AW'(1);
            rd_req    <= 1'b1;
            out_idx   <= '0;
            seq_cnt   <= 3'd0;
            cnt       <= 2'd0;
            state     <= PREFETCH;
          end
        end
        PREFETCH: state <= STREAM;
        STREAM: begin
          if (fire && m_axis_tlast) begin
            seq_num    <= seq_num + 32'd1;
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
